// File: rtl/adder_sum_accumulator.sv
// Accumulates N_OPS {carry,sum} beats from the 2-bit adder stage into a
// running total, then holds the result behind a valid/ready handshake.
module adder_sum_accumulator #(
   parameter int unsigned ACC_W = 8,
   parameter int unsigned N_OPS = 4,
   parameter int unsigned CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_sum,
   input  logic             in_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             ovf,
   output logic [CNT_W-1:0] op_count
);

   localparam int unsigned SUM_W = ACC_W + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_OPS - 1);

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [ACC_W-1:0]   acc_d;
   logic               ovf_d;
   logic [CNT_W-1:0]   cnt_d;
   logic [2:0]         beat_c;
   logic [SUM_W-1:0]   sum_c;
   logic               accept_c;
   logic               last_beat_c;

   // Beat value and the widened sum; the extra MSB is the wrap carry.
   assign beat_c      = {in_carry, in_sum};
   assign sum_c       = {1'b0, acc_out} + SUM_W'(beat_c);
   assign accept_c    = in_valid && in_ready;
   assign last_beat_c = (op_count == LAST_CNT);

   // Next-state and next-datapath decode; clr overrides any handshake.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_out;
      ovf_d   = ovf;
      cnt_d   = op_count;
      if (clr) begin
         state_d = ACCUM;
         acc_d   = '0;
         ovf_d   = 1'b0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (accept_c) begin
                  acc_d = sum_c[ACC_W-1:0];
                  ovf_d = ovf | sum_c[ACC_W];
                  if (last_beat_c) begin
                     state_d = DONE;
                  end else begin
                     cnt_d = op_count + CNT_W'(1);
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_d = ACCUM;
                  acc_d   = '0;
                  ovf_d   = 1'b0;
                  cnt_d   = '0;
               end
            end
            default: state_d = ACCUM;
         endcase
      end
   end

   // State and datapath registers; handshake flags track the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ACCUM;
         acc_out   <= '0;
         ovf       <= 1'b0;
         op_count  <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_out   <= acc_d;
         ovf       <= ovf_d;
         op_count  <= cnt_d;
         in_ready  <= (state_d == ACCUM);
         out_valid <= (state_d == DONE);
      end
   end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Directed bench: a default-width instance driven from a vector table, plus a
// 4-bit instance sharing the same inputs for the wrap/overflow case.
module tb_adder_sum_accumulator;

   logic       clk = 1'b0;
   logic       reset;
   logic       clr;
   logic       in_valid;
   logic [1:0] in_sum;
   logic       in_carry;
   logic       out_ready;

   logic       in_ready,  out_valid,  ovf;
   logic [7:0] acc_out;
   logic [2:0] op_count;
   logic       in_ready4, out_valid4, ovf4;
   logic [3:0] acc_out4;
   logic [2:0] op_count4;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   adder_sum_accumulator dut (
      .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid),
      .in_ready(in_ready), .in_sum(in_sum), .in_carry(in_carry),
      .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
      .ovf(ovf), .op_count(op_count)
   );

   adder_sum_accumulator #(.ACC_W(4), .N_OPS(4), .CNT_W(3)) dut4 (
      .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid),
      .in_ready(in_ready4), .in_sum(in_sum), .in_carry(in_carry),
      .out_valid(out_valid4), .out_ready(out_ready), .acc_out(acc_out4),
      .ovf(ovf4), .op_count(op_count4)
   );

   typedef struct {
      logic       vld;
      logic [2:0] v;
      logic       clr;
      logic       ordy;
      logic [7:0] e_acc;
      logic [2:0] e_cnt;
      logic       e_ovf;
      logic       e_ovld;
      logic       e_irdy;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic vld, input logic [2:0] v, input logic c,
                      input logic ordy, input logic [7:0] acc,
                      input logic [2:0] cnt, input logic ov,
                      input logic ovld, input logic irdy);
      vec_t r;
      r.vld = vld; r.v = v; r.clr = c; r.ordy = ordy;
      r.e_acc = acc; r.e_cnt = cnt; r.e_ovf = ov; r.e_ovld = ovld; r.e_irdy = irdy;
      vecs.push_back(r);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic vld, input logic [2:0] v, input logic c,
                        input logic ordy);
      in_valid  = vld;
      in_carry  = v[2];
      in_sum    = v[1:0];
      clr       = c;
      out_ready = ordy;
   endtask

   // Advance one clock; outputs are sampled 1ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_main(input string tag, input int acc, input int cnt,
                           input int ov, input int ovld, input int irdy);
      chk({tag, ".acc"},  int'(acc_out),   acc);
      chk({tag, ".cnt"},  int'(op_count),  cnt);
      chk({tag, ".ovf"},  int'(ovf),       ov);
      chk({tag, ".ovld"}, int'(out_valid), ovld);
      chk({tag, ".irdy"}, int'(in_ready),  irdy);
   endtask

   initial begin
      // T2: back-to-back 3,6,1,2, held result (with ignored beats), then taken
      add(1, 3'd3, 0, 0,  3, 1, 0, 0, 1);
      add(1, 3'd6, 0, 0,  9, 2, 0, 0, 1);
      add(1, 3'd1, 0, 0, 10, 3, 0, 0, 1);
      add(1, 3'd2, 0, 0, 12, 3, 0, 1, 0);
      add(1, 3'd6, 0, 0, 12, 3, 0, 1, 0);
      add(1, 3'd6, 0, 0, 12, 3, 0, 1, 0);
      add(0, 3'd0, 0, 0, 12, 3, 0, 1, 0);
      add(1, 3'd6, 0, 1,  0, 0, 0, 0, 1);
      // T4: bubbles 1,0,0,1,0,1,1 with v=1
      add(1, 3'd1, 0, 0,  1, 1, 0, 0, 1);
      add(0, 3'd1, 0, 0,  1, 1, 0, 0, 1);
      add(0, 3'd1, 0, 0,  1, 1, 0, 0, 1);
      add(1, 3'd1, 0, 0,  2, 2, 0, 0, 1);
      add(0, 3'd1, 0, 0,  2, 2, 0, 0, 1);
      add(1, 3'd1, 0, 0,  3, 3, 0, 0, 1);
      add(1, 3'd1, 0, 0,  4, 3, 0, 1, 0);
      add(0, 3'd0, 0, 1,  0, 0, 0, 0, 1);
      // T5: clr after two beats of 5, with a dropped beat of 6 in the clr cycle
      add(1, 3'd5, 0, 0,  5, 1, 0, 0, 1);
      add(1, 3'd5, 0, 0, 10, 2, 0, 0, 1);
      add(1, 3'd6, 1, 0,  0, 0, 0, 0, 1);
      add(1, 3'd1, 0, 0,  1, 1, 0, 0, 1);
      add(1, 3'd1, 0, 0,  2, 2, 0, 0, 1);
      add(1, 3'd1, 0, 0,  3, 3, 0, 0, 1);
      add(1, 3'd1, 0, 0,  4, 3, 0, 1, 0);
      // T6: clr in DONE discards the result
      add(1, 3'd6, 1, 0,  0, 0, 0, 0, 1);

      // T1: reset for two cycles
      reset = 1'b1;
      drive(0, 3'd0, 0, 0);
      step();
      step();
      reset = 1'b0;
      chk_main("t1", 0, 0, 0, 0, 1);

      foreach (vecs[i]) begin
         drive(vecs[i].vld, vecs[i].v, vecs[i].clr, vecs[i].ordy);
         step();
         chk_main($sformatf("vec%0d", i), int'(vecs[i].e_acc), int'(vecs[i].e_cnt),
                  int'(vecs[i].e_ovf), int'(vecs[i].e_ovld), int'(vecs[i].e_irdy));
      end

      // T3: four beats of 6 wrap the 4-bit instance (24 mod 16 = 8)
      drive(1, 3'd6, 0, 0);
      step();
      chk("t3.b1.acc4", int'(acc_out4), 6);
      chk("t3.b1.ovf4", int'(ovf4), 0);
      step();
      chk("t3.b2.acc4", int'(acc_out4), 12);
      step();
      chk("t3.b3.acc4", int'(acc_out4), 2);
      chk("t3.b3.ovf4", int'(ovf4), 1);
      step();
      chk("t3.acc4",  int'(acc_out4), 8);
      chk("t3.ovf4",  int'(ovf4), 1);
      chk("t3.ovld4", int'(out_valid4), 1);
      chk("t3.acc8",  int'(acc_out), 24);
      chk("t3.ovf8",  int'(ovf), 0);
      drive(0, 3'd0, 0, 1);
      step();
      chk("t3.taken.ovf4",  int'(ovf4), 0);
      chk("t3.taken.acc4",  int'(acc_out4), 0);
      chk("t3.taken.irdy4", int'(in_ready4), 1);

      // T6: reset while holding a result
      drive(1, 3'd2, 0, 0);
      repeat (4) step();
      chk("t6.pre.ovld", int'(out_valid), 1);
      chk("t6.pre.acc",  int'(acc_out), 8);
      reset = 1'b1;
      drive(1, 3'd6, 0, 1);
      step();
      reset = 1'b0;
      chk_main("t6.rst", 0, 0, 0, 0, 1);

      // Final-beat latency: out_valid must not rise in the beat cycle itself
      drive(1, 3'd4, 0, 0);
      repeat (3) step();
      chk("lat.pre.ovld", int'(out_valid), 0);
      step();
      chk("lat.ovld", int'(out_valid), 1);
      chk("lat.acc",  int'(acc_out), 16);
      drive(0, 3'd0, 0, 1);
      step();
      chk_main("lat.taken", 0, 0, 0, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
